// File: rtl/dictionary_ctx_bank.sv
// Multi-context dictionary: values are streamed into per-context regions of a
// shared simple dual-port memory, then looked up by index with in-order results.
module dictionary_ctx_bank #(
  parameter int unsigned        VALUE_W       = 32,
  parameter int unsigned        ID_W          = 16,
  parameter int unsigned        DEPTH         = 1024,
  parameter int unsigned        NUM_CTX       = 4,
  parameter int unsigned        READ_LATENCY  = 2,
  parameter logic [VALUE_W-1:0] DEFAULT_VALUE = '0,
  localparam int unsigned       CTX_W         = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_value_valid,
  output logic               in_value_ready,
  input  logic [VALUE_W-1:0] in_value_data,
  input  logic [CTX_W-1:0]   in_value_ctx,
  input  logic               in_value_last,
  input  logic               in_id_valid,
  output logic               in_id_ready,
  input  logic [ID_W-1:0]    in_id_data,
  input  logic [CTX_W-1:0]   in_id_ctx,
  input  logic               in_id_keep,
  input  logic               in_id_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VALUE_W-1:0] out_data,
  output logic               out_hit,
  output logic               out_keep,
  output logic               out_last,
  output logic [NUM_CTX-1:0] ctx_loaded,
  output logic [NUM_CTX-1:0] ctx_overflow
);

  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned CNT_W      = IDX_W + 1;
  localparam int unsigned FIFO_DEPTH = READ_LATENCY + 2;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic valid;
    logic hit;
    logic keep;
    logic last;
  } tag_t;

  typedef struct packed {
    logic [VALUE_W-1:0] data;
    logic               hit;
    logic               keep;
    logic               last;
  } res_t;

  logic [CNT_W-1:0]     count [NUM_CTX];
  logic [NUM_CTX-1:0]   loaded, overflow, armed;
  logic [VALUE_W-1:0]   mem [NUM_CTX*DEPTH];
  logic [VALUE_W-1:0]   rd_q [READ_LATENCY];
  tag_t                 tag_q [READ_LATENCY];
  res_t                 fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]     fifo_wr, fifo_rd;
  logic [OCC_W-1:0]     fifo_count, inflight;
  logic [OCC_W:0]       occupancy;

  logic                 value_fire, id_fire, push, pop;
  logic                 lookup_hit, rd_en, wr_en, reload_hazard;
  logic [CNT_W-1:0]     sel_count, id_count;
  logic [ID_W+CNT_W-1:0] id_ext, cnt_ext;
  logic [IDX_W-1:0]     wr_idx;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign sel_count = count[in_value_ctx];
  assign id_count  = count[in_id_ctx];

  // Space is reserved at accept time, so a result leaving the read pipe always fits.
  assign occupancy   = {1'b0, inflight} + {1'b0, fifo_count};
  assign in_id_ready = !rst && loaded[in_id_ctx] && (occupancy < (OCC_W+1)'(FIFO_DEPTH));
  assign id_fire     = in_id_valid && in_id_ready;

  // Reloading rewrites index 0 of a live context; wait until no read of it can be pending.
  assign reload_hazard  = armed[in_value_ctx] && loaded[in_value_ctx] &&
                          ((inflight != '0) || (id_fire && (in_id_ctx == in_value_ctx)));
  assign in_value_ready = !rst && !reload_hazard;
  assign value_fire     = in_value_valid && in_value_ready;

  assign id_ext     = {{CNT_W{1'b0}}, in_id_data};
  assign cnt_ext    = {{ID_W{1'b0}}, id_count};
  assign lookup_hit = in_id_keep && (id_ext < cnt_ext);
  assign rd_en      = id_fire && lookup_hit;
  assign wr_en      = value_fire && (armed[in_value_ctx] || (sel_count < CNT_W'(DEPTH)));
  assign wr_idx     = armed[in_value_ctx] ? '0 : sel_count[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) mem[{in_value_ctx, wr_idx}] <= in_value_data;
    if (rd_en) rd_q[0] <= mem[{in_id_ctx, in_id_data[IDX_W-1:0]}];
    for (int unsigned i = 1; i < READ_LATENCY; i++) rd_q[i] <= rd_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded   <= '0;
      overflow <= '0;
      armed    <= '1;
      for (int unsigned c = 0; c < NUM_CTX; c++) count[c] <= '0;
    end else if (value_fire) begin
      if (armed[in_value_ctx]) begin
        count[in_value_ctx]    <= CNT_W'(1);
        overflow[in_value_ctx] <= 1'b0;
      end else if (sel_count < CNT_W'(DEPTH)) begin
        count[in_value_ctx] <= sel_count + 1'b1;
      end else begin
        overflow[in_value_ctx] <= 1'b1;
      end
      loaded[in_value_ctx] <= in_value_last;
      armed[in_value_ctx]  <= in_value_last;
    end
  end

  assign push = tag_q[READ_LATENCY-1].valid;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      fifo_wr    <= '0;
      fifo_rd    <= '0;
    end else begin
      tag_q[0] <= '{valid: id_fire, hit: lookup_hit, keep: in_id_keep, last: in_id_last};
      for (int unsigned i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      inflight   <= inflight + OCC_W'(id_fire) - OCC_W'(push);
      fifo_count <= fifo_count + OCC_W'(push) - OCC_W'(pop);
      if (push) fifo_wr <= next_ptr(fifo_wr);
      if (pop)  fifo_rd <= next_ptr(fifo_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[fifo_wr] <= '{data: tag_q[READ_LATENCY-1].hit ? rd_q[READ_LATENCY-1] : DEFAULT_VALUE,
                         hit:  tag_q[READ_LATENCY-1].hit,
                         keep: tag_q[READ_LATENCY-1].keep,
                         last: tag_q[READ_LATENCY-1].last};
    end
  end

  assign out_valid    = (fifo_count != '0);
  assign out_data     = fifo[fifo_rd].data;
  assign out_hit      = fifo[fifo_rd].hit;
  assign out_keep     = fifo[fifo_rd].keep;
  assign out_last     = fifo[fifo_rd].last;
  assign ctx_loaded   = loaded;
  assign ctx_overflow = overflow;

endmodule

// File: doc/dictionary_ctx_bank.md
DICTIONARY_CTX_BANK -- requirements
Module: dictionary_ctx_bank

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have VALUE_W, 32: value width in bits.
REQ-002 SHALL have ID_W, 16: lookup id width in bits.
REQ-003 SHALL have DEPTH, 1024: entries per context, power of two, at most 2^ID_W.
REQ-004 SHALL have NUM_CTX, 4: independent dictionary contexts, power of two; CTX_W = max(1, clog2(NUM_CTX)).
REQ-005 SHALL have READ_LATENCY, 2: memory read latency in cycles, 1 or 2.
REQ-006 SHALL have DEFAULT_VALUE, 0: value returned on a miss or a masked lane.

Ports (name, direction, width, meaning):
REQ-007 SHALL have clk, in, 1: single clock.
REQ-008 SHALL have rst, in, 1: one clock; reset is synchronous and active-high.
REQ-009 SHALL have in_value_valid/in_value_ready, in/out, 1 each: load handshake.
REQ-010 SHALL have in_value_data, in_value_ctx, in_value_last, in, VALUE_W / CTX_W / 1: load value, target context, end-of-column marker.
REQ-011 SHALL have in_id_valid/in_id_ready, in/out, 1 each: lookup handshake.
REQ-012 SHALL have in_id_data, in_id_ctx, in_id_keep, in_id_last, in, ID_W / CTX_W / 1 / 1: lookup id, context, lane valid, end-of-stream marker.
REQ-013 SHALL have out_valid/out_ready, out/in, 1 each: result handshake.
REQ-014 SHALL have out_data, out_hit, out_keep, out_last, out, VALUE_W / 1 / 1 / 1: result value, hit flag, forwarded keep, forwarded last.
REQ-015 SHALL have ctx_loaded and ctx_overflow, out, NUM_CTX each: per-context status bits.

Function
REQ-016 SHALL store NUM_CTX*DEPTH values in simple dual-port memory at address {ctx, index}, with one write port and one read port.
REQ-017 Load: each accepted value beat SHALL write to wr_ptr[ctx] and increment it; count[ctx] = number of stored entries.
REQ-018 Load, first beat into a context: that beat SHALL clear ctx_loaded[ctx], ctx_overflow[ctx] and count[ctx], and SHALL write at index 0.
REQ-019 Load, beat with in_value_last: SHALL set ctx_loaded[ctx] and rearm the context, so the next beat is a first beat.
REQ-020 Load overflow: beats beyond DEPTH SHALL be accepted and dropped; count saturates at DEPTH and ctx_overflow[ctx] is set sticky until the next reload.
REQ-021 Reload hazard: a first beat into a context that currently has ctx_loaded=1 SHALL hold in_value_ready=0 until no lookup is in flight.
REQ-022 Apart from REQ-021, in_value_ready SHALL be 1 outside reset.
REQ-023 Lookup accept: in_id_ready = ctx_loaded[in_id_ctx] AND (inflight + fifo_count < FIFO_DEPTH), where FIFO_DEPTH = READ_LATENCY+2.
REQ-024 Lookups SHALL stall, never drop, while their context is unloaded.
REQ-025 Lookup hit: keep=1 and in_id_data < count[ctx] SHALL issue a memory read and return the stored value with out_hit=1.
REQ-026 Lookup miss: keep=1 and in_id_data >= count[ctx] SHALL issue no read and return DEFAULT_VALUE with out_hit=0.
REQ-027 Masked lane: keep=0 SHALL return DEFAULT_VALUE with out_hit=0 and out_keep=0; out_last is always forwarded unchanged.
REQ-028 Latency: with the FIFO empty and out_ready=1, a result SHALL appear exactly READ_LATENCY+1 cycles after id accept; throughput is one result per cycle.
REQ-029 Results SHALL leave in lookup-acceptance order, and out_* SHALL stay stable while out_valid=1 and out_ready=0.
REQ-030 Simultaneous load (context A) and lookup (context B != A) in one cycle SHALL both proceed.
REQ-031 A write and a read to the same address in one cycle SHALL NOT occur; REQ-021 and REQ-024 guarantee this.
REQ-032 inflight counter SHALL never exceed FIFO_DEPTH, and the FIFO SHALL never overflow.

Reset
REQ-033 On rst=1 at a clock edge, the block SHALL set: out_valid=0; in_id_ready=0; ctx_loaded=0; ctx_overflow=0; all count=0; all wr_ptr=0; inflight=0; FIFO empty.
REQ-034 in_value_ready SHALL be 0 during reset and 1 in the first cycle after reset deasserts.
REQ-035 Memory contents SHALL NOT be reset, and no lookup SHALL read an entry before it is reloaded.
REQ-036 Reset mid-load or mid-lookup SHALL discard all partial state and in-flight results, with no out_valid pulse afterwards.

Verification (NUM_CTX=2, DEPTH=16, READ_LATENCY=2, DEFAULT_VALUE=0xDEAD)
REQ-037 SHALL cover: load ctx0 with 100..104, last on 104; ids 4,0,2 back-to-back -> out 104,100,102, hit=1, first result 3 cycles after accept, then one per cycle.
REQ-038 SHALL cover: id 7 on ctx0 (count 5) and a keep=0 lane -> 0xDEAD hit=0 keep=1, then 0xDEAD hit=0 keep=0; last forwarded.
REQ-039 SHALL cover: 20 ids streamed with out_ready=0 for 10 cycles -> at most 4 accepted before in_id_ready=0, no loss, order preserved after release.
REQ-040 SHALL cover: 18 values into ctx1 -> count=16, ctx_overflow[1]=1; id 15 returns the 16th value.
REQ-041 SHALL cover: id on ctx1 before its load -> in_id_ready=0 until the last beat; reload ctx0 with 3 lookups in flight -> in_value_ready=0 until they drain; old results correct.
REQ-042 SHALL cover: rst pulsed after 3 ctx0 load beats -> ctx_loaded=0, out_valid=0; reload plus lookup then behaves as the first scenario.
